// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 2-of-3 majority voting per bit,
// runtime parity selection, 1/2 stop bits and a valid/ready output with error flags.
// Optional feature macro: UART_RX_BREAK_EN (break detection and BREAK state).
module uart_rx_os #(
   parameter int DATA_WIDTH    = 8,
   parameter int DIVIDER_WIDTH = 32,
   parameter int OVERSAMPLE    = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic                     parity_odd_i,
   input  logic                     parity_even_i,
   input  logic                     stop2_i,
   input  logic                     rx_i,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
   output logic                     m_axis_tvalid_o,
   input  logic                     m_axis_tready_i,
   output logic                     parity_err_o,
   output logic                     frame_err_o,
   output logic                     overrun_o,
   output logic                     break_o
);

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_WIDTH + 1);
   localparam logic [OSW-1:0] SMP0  = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] SMP1  = OSW'(OVERSAMPLE / 2);
   localparam logic [OSW-1:0] SMP2  = OSW'(OVERSAMPLE / 2 + 1);
   localparam logic [OSW-1:0] OSTOP = OSW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
`ifdef UART_RX_BREAK_EN
      S_STOP,
      S_BREAK
`else
      S_STOP
`endif
   } state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     rx_prev_q;
   logic [DIVIDER_WIDTH-1:0] tick_cnt_q, div_q;
   logic [OSW-1:0]           os_cnt_q;
   logic [1:0]               samp_q;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
   logic                     par_en_q, par_odd_q, stop2_q;
   logic                     stop_idx_q, stop_idx_d;
   logic                     perr_q, perr_d, ferr_q, ferr_d;
   logic [DATA_WIDTH-1:0]    tdata_q;
   logic                     tvalid_q, operr_q, oferr_q, overrun_q;

   logic                     rx_s, start_edge, tick, vote, bit_end, exp_par, done;
   logic                     at_s0, at_s1, at_s2;
   logic [DIVIDER_WIDTH-1:0] div_live, div_top;

`ifdef UART_RX_BREAK_EN
   logic                     zero_q, zero_d, brk, break_q;
   logic [OSW-1:0]           hi_cnt_q, hi_cnt_d;
`endif

   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign div_live   = (clk_divider_i == '0) ? DIVIDER_WIDTH'(1) : clk_divider_i;
   assign div_top    = ((state_q == S_IDLE) ? div_live : div_q) - DIVIDER_WIDTH'(1);
   // >= keeps the counter sane if the live divider shrinks while idling
   assign tick       = (tick_cnt_q >= div_top);
   assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_s;
   assign at_s0      = tick && (os_cnt_q == SMP0);
   assign at_s1      = tick && (os_cnt_q == SMP1);
   assign at_s2      = tick && (os_cnt_q == SMP2);
   assign bit_end    = tick && (os_cnt_q == OSTOP);
   // the third sample is taken live, so the vote is ready on the at_s2 cycle
   assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
   assign exp_par    = par_odd_q ? ~^shreg_q : ^shreg_q;

   // rx_i synchroniser plus previous-value flop for start-edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rx_prev_q <= rx_s;
      end
   end

   // tick/oversample counters, mid-bit samples and per-frame config capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt_q <= '0;
         os_cnt_q   <= '0;
         div_q      <= '0;
         samp_q     <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
      end else begin
         if (start_edge) begin
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            div_q      <= div_live;
            par_en_q   <= parity_odd_i | parity_even_i;
            par_odd_q  <= parity_odd_i;
            stop2_q    <= stop2_i;
         end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + DIVIDER_WIDTH'(1);
            if (state_q == S_IDLE)
               os_cnt_q <= '0;
            else if (tick)
               os_cnt_q <= (os_cnt_q == OSTOP) ? '0 : os_cnt_q + OSW'(1);
         end
         if (at_s0) samp_q[0] <= rx_s;
         if (at_s1) samp_q[1] <= rx_s;
      end
   end

   // frame FSM state and frame-accumulated datapath
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         stop_idx_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
         zero_q     <= 1'b0;
         hi_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         stop_idx_q <= stop_idx_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
`ifdef UART_RX_BREAK_EN
         zero_q     <= zero_d;
         hi_cnt_q   <= hi_cnt_d;
`endif
      end
   end

   // next-state and word-complete decode
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      stop_idx_d = stop_idx_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      done       = 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_d     = zero_q;
      hi_cnt_d   = hi_cnt_q;
      brk        = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            bit_cnt_d  = '0;
            stop_idx_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_d     = 1'b1;
`endif
            if (start_edge) state_d = S_START;
         end
         S_START: begin
            // a high mid-bit vote means the falling edge was a glitch
            if (at_s2 && vote) state_d = S_IDLE;
            else if (bit_end)  state_d = S_DATA;
         end
         S_DATA: begin
            if (at_s2) begin
               shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_EN
               zero_d  = zero_q & ~vote;
`endif
            end
            if (bit_end) begin
               if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_s2) begin
               perr_d = (vote != exp_par);
`ifdef UART_RX_BREAK_EN
               zero_d = zero_q & ~vote;
`endif
            end
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (at_s2) begin
               ferr_d = ferr_q | ~vote;
               // leave at the mid-point of the last stop bit so a back-to-back start edge is seen
               if (stop_idx_q == stop2_q) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
`ifdef UART_RX_BREAK_EN
               if (!stop_idx_q && zero_q && !vote) begin
                  done     = 1'b0;
                  brk      = 1'b1;
                  hi_cnt_d = '0;
                  state_d  = S_BREAK;
               end
`endif
            end else if (bit_end) begin
               stop_idx_d = 1'b1;
            end
         end
`ifdef UART_RX_BREAK_EN
         S_BREAK: begin
            // wait for one full bit time of continuous idle-high line
            if (tick) begin
               if (!rx_s) begin
                  hi_cnt_d = '0;
               end else if (hi_cnt_q == OSTOP) begin
                  hi_cnt_d = '0;
                  state_d  = S_IDLE;
               end else begin
                  hi_cnt_d = hi_cnt_q + OSW'(1);
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // output holding register with overrun drop policy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         operr_q   <= 1'b0;
         oferr_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done) begin
            if (tvalid_q && !m_axis_tready_i) begin
               overrun_q <= 1'b1;
            end else begin
               tdata_q  <= shreg_q;
               operr_q  <= perr_q;
               oferr_q  <= ferr_d;
               tvalid_q <= 1'b1;
            end
         end else if (tvalid_q && m_axis_tready_i) begin
            tvalid_q <= 1'b0;
         end
      end
   end

`ifdef UART_RX_BREAK_EN
   // one-cycle break pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) break_q <= 1'b0;
      else       break_q <= brk;
   end
   assign break_o = break_q;
`else
   assign break_o = 1'b0;
`endif

   assign m_axis_tdata_o  = tdata_q;
   assign m_axis_tvalid_o = tvalid_q;
   assign parity_err_o    = operr_q;
   assign frame_err_o     = oferr_q;
   assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: table vectors, hand-written corner sequences
// and randomized frames checked against a line-level frame decoder model.
module tb_uart_rx_os;
   localparam int BIT = 32;   // clk_divider 2 x oversample 16

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] div;
   logic        par_odd, par_even, stop2, rx, tready;
   logic [7:0]  tdata;
   logic        tvalid, perr, ferr, ovr, brk;

   always #5 clk = ~clk;

   uart_rx_os dut (
      .clk_i(clk), .rst_i(rst), .clk_divider_i(div),
      .parity_odd_i(par_odd), .parity_even_i(par_even), .stop2_i(stop2), .rx_i(rx),
      .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
      .parity_err_o(perr), .frame_err_o(ferr), .overrun_o(ovr), .break_o(brk)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } word_t;

   typedef struct {
      string      name;
      logic [7:0] data;
      int         pmode;     // 0 none, 1 even, 2 odd
      logic       pbit;
      logic       s2;
      logic [1:0] stops;     // [0] first stop level, [1] second
      logic [7:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   int    checks = 0, failures = 0;
   int    cyc = 0, rise_cyc = 0, start_cyc = 0, ovr_cnt = 0, brk_cnt = 0;
   logic  tv_prev = 1'b0;
   word_t got_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // observe handshakes and pulses away from the active edge
   always @(negedge clk) begin
      if (tvalid && tready) got_q.push_back({tdata, perr, ferr});
      if (ovr) ovr_cnt++;
      if (brk) brk_cnt++;
      if (tvalid && !tv_prev) rise_cyc = cyc;
      tv_prev = tvalid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic void build(input logic [7:0] d, input int pm, input logic pb,
                                 input logic s2, input logic [1:0] sl,
                                 output logic [11:0] fr, output int n);
      fr    = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[1+i] = d[i];
      n = 9;
      if (pm != 0) begin
         fr[n] = pb;
         n++;
      end
      fr[n] = sl[0];
      n++;
      if (s2) begin
         fr[n] = sl[1];
         n++;
      end
   endfunction

   // decode a frame as seen on the line: parity by counting ones, stop bits must be high
   function automatic word_t model(input logic [11:0] fr, input int n, input int pm, input logic s2);
      word_t w;
      int    ones;
      w.d  = fr[8:1];
      w.pe = 1'b0;
      if (pm != 0) begin
         ones = $countones(fr[9:1]);
         w.pe = (pm == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      end
      w.fe = (fr[n-1] == 1'b0) || (s2 && fr[n-2] == 1'b0);
      return w;
   endfunction

   task automatic send(input logic [11:0] fr, input int n);
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         rx = fr[i];
         step(BIT);
      end
      rx = 1'b1;
   endtask

   task automatic set_cfg(input int pm, input logic s2, input logic even_too);
      par_even = (pm == 1) || (pm == 2 && even_too);
      par_odd  = (pm == 2);
      stop2    = s2;
   endtask

   // send one frame with tready high and check the single delivered word
   task automatic run_frame(input string name, input logic [7:0] d, input int pm, input logic pb,
                            input logic s2, input logic [1:0] sl, input word_t exp);
      logic [11:0] fr;
      int          n, k, lat;
      word_t       w;
      build(d, pm, pb, s2, sl, fr, n);
      got_q.delete();
      send(fr, n);
      step(BIT + $urandom_range(0, 20));
      check({name, " count"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         w = got_q.pop_front();
         check({name, " tdata"}, w.d, exp.d);
         check({name, " parity_err"}, w.pe, exp.pe);
         check({name, " frame_err"}, w.fe, exp.fe);
      end
      // tvalid must rise just after the last stop bit's mid-point, within a few cycles of sync delay
      k   = n - 1;
      lat = rise_cyc - start_cyc;
      check({name, " latency_window"}, (lat >= k*BIT + BIT/2) && (lat <= k*BIT + BIT/2 + 12), 1);
   endtask

   initial begin
      vec_t        vecs[6];
      logic [11:0] fr;
      int          n, pm;
      logic [7:0]  d;
      logic        pb, s2;
      logic [1:0]  sl;

      vecs[0] = '{"T1_8N1_A5",      8'hA5, 0, 1'b0, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{"T2_even_bad",    8'h0F, 1, 1'b1, 1'b0, 2'b11, 8'h0F, 1'b1, 1'b0};
      vecs[2] = '{"T2_even_good",   8'h0F, 1, 1'b0, 1'b0, 2'b11, 8'h0F, 1'b0, 1'b0};
      vecs[3] = '{"T5_stop2_bad",   8'h55, 0, 1'b0, 1'b1, 2'b01, 8'h55, 1'b0, 1'b1};
      vecs[4] = '{"odd_good_00",    8'h00, 2, 1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{"stop2_first_lo", 8'h80, 1, 1'b0, 1'b1, 2'b10, 8'h80, 1'b1, 1'b1};

      rst = 1'b1; div = 32'd2; par_odd = 1'b0; par_even = 1'b0; stop2 = 1'b0;
      rx = 1'b1; tready = 1'b1;
      step(5);
      check("reset tvalid", tvalid, 0);
      check("reset tdata", tdata, 0);
      check("reset parity_err", perr, 0);
      check("reset frame_err", ferr, 0);
      check("reset overrun", ovr, 0);
      check("reset break", brk, 0);
      rst = 1'b0;
      step(2*BIT);

      for (int i = 0; i < 6; i++) begin
         set_cfg(vecs[i].pmode, vecs[i].s2, 1'b0);
         run_frame(vecs[i].name, vecs[i].data, vecs[i].pmode, vecs[i].pbit, vecs[i].s2,
                   vecs[i].stops, {vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe});
      end

      // glitch shorter than half a bit is rejected, then a clean frame decodes
      set_cfg(0, 1'b0, 1'b0);
      got_q.delete();
      rx = 1'b0;
      step(8);
      rx = 1'b1;
      step(2*BIT);
      check("T3 glitch no word", got_q.size(), 0);
      check("T3 glitch tvalid", tvalid, 0);
      run_frame("T3_3C", 8'h3C, 0, 1'b0, 1'b0, 2'b11, {8'h3C, 1'b0, 1'b0});

      // overrun: second word dropped while the first is stalled
      tready = 1'b0;
      ovr_cnt = 0;
      got_q.delete();
      build(8'h11, 0, 1'b0, 1'b0, 2'b11, fr, n);
      send(fr, n);
      build(8'h22, 0, 1'b0, 1'b0, 2'b11, fr, n);
      send(fr, n);
      step(2*BIT);
      check("T4 overrun pulses", ovr_cnt, 1);
      check("T4 held tvalid", tvalid, 1);
      check("T4 held tdata", tdata, 8'h11);
      tready = 1'b1;
      step(4);
      check("T4 transfers", got_q.size(), 1);
      if (got_q.size() > 0) check("T4 transferred word", got_q[0].d, 8'h11);
      check("T4 tvalid after", tvalid, 0);

      // line held low for 12 bit times
      brk_cnt = 0;
      got_q.delete();
      rx = 1'b0;
      step(12*BIT);
      rx = 1'b1;
      step(3*BIT);
`ifdef UART_RX_BREAK_EN
      check("T6 break pulses", brk_cnt, 1);
      check("T6 break no word", got_q.size(), 0);
`else
      check("T6 break pulses", brk_cnt, 0);
      check("T6 break word count", got_q.size(), 1);
      if (got_q.size() > 0) begin
         check("T6 break tdata", got_q[0].d, 8'h00);
         check("T6 break frame_err", got_q[0].fe, 1);
      end
`endif
      run_frame("T6_recover", 8'h5A, 0, 1'b0, 1'b0, 2'b11, {8'h5A, 1'b0, 1'b0});

      // reset mid-frame with a word pending
      tready = 1'b0;
      build(8'h77, 0, 1'b0, 1'b0, 2'b11, fr, n);
      send(fr, n);
      step(BIT);
      check("T6 pending before reset", tvalid, 1);
      rx = 1'b0;
      step(BIT);
      rx = 1'b1;
      step(BIT + 5);
      rst = 1'b1;
      step(1);
      check("T6 reset tvalid", tvalid, 0);
      check("T6 reset frame_err", ferr, 0);
      rst = 1'b0;
      tready = 1'b1;
      step(2*BIT);
      run_frame("T6_after_reset", 8'h96, 0, 1'b0, 1'b0, 2'b11, {8'h96, 1'b0, 1'b0});

      // randomized frames against the line decoder model
      for (int r = 0; r < 10; r++) begin
         d  = 8'($urandom_range(1, 255));
         pm = $urandom_range(0, 2);
         pb = 1'($urandom);
         s2 = 1'($urandom);
         sl = 2'($urandom);
         set_cfg(pm, s2, 1'($urandom));
         build(d, pm, pb, s2, sl, fr, n);
         run_frame($sformatf("rand%0d", r), d, pm, pb, s2, sl, model(fr, n, pm, s2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
